// File: rtl/regfile_bist.sv
// March-test BIST controller for a 32x32 register file; owns the write and read ports while Busy.
// Optional macro REGFILE_BIST_STOP_ON_FAIL_EN: end the sequence on the first mismatching read.
module regfile_bist #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDRBITS = 5
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    output logic                Busy,
    output logic                Done,
    output logic                Pass,
    output logic [ADDRBITS-1:0] FailAddr,
    output logic [1:0]          FailPort,
    output logic [7:0]          ErrCount,
    input  logic [WIDTH-1:0]    ReadData1,
    input  logic [WIDTH-1:0]    ReadData2,
    output logic [WIDTH-1:0]    WriteData,
    output logic [ADDRBITS-1:0] WriteRegister,
    output logic                RegWrite,
    output logic [ADDRBITS-1:0] ReadRegister1,
    output logic [ADDRBITS-1:0] ReadRegister2
);

    localparam int unsigned ERR_W  = 8;
    localparam int unsigned ERR_SW = ERR_W + 1;
    localparam logic [ADDRBITS-1:0] K_LAST    = '1;
    localparam logic [WIDTH-1:0]    HOLD_DATA = WIDTH'(32'hDEADBEEF);
    localparam logic [ERR_W-1:0]    ERR_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL_A, S_CHECK_A, S_FILL_B, S_CHECK_B, S_HOLD, S_CHECK_H, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDRBITS-1:0] k_q, k_d;
    logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ADDRBITS-1:0] fail_addr_q, fail_addr_d;
    logic [1:0]          fail_port_q, fail_port_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;
    logic [WIDTH-1:0]    wr_data_q, wr_data_d;
    logic [ADDRBITS-1:0] wr_reg_q, wr_reg_d, rd_reg1_q, rd_reg1_d, rd_reg2_q, rd_reg2_d;
    logic                reg_write_q, reg_write_d;

    logic                is_check;
    logic [1:0]          mism;
    logic [ERR_SW-1:0]   err_sum;

    function automatic logic [WIDTH-1:0] pat_a(input logic [ADDRBITS-1:0] k);
        return WIDTH'(k);
    endfunction

    // Register zero always reads back zero; the rest hold the pattern of the last fill.
    function automatic logic [WIDTH-1:0] expected(input state_t s, input logic [ADDRBITS-1:0] r);
        if (r == '0)          return '0;
        else if (s == S_CHECK_A) return pat_a(r);
        else                  return ~pat_a(r);
    endfunction

    function automatic state_t next_sweep(input state_t s);
        case (s)
            S_FILL_A:  return S_CHECK_A;
            S_CHECK_A: return S_FILL_B;
            S_FILL_B:  return S_CHECK_B;
            S_CHECK_B: return S_HOLD;
            S_HOLD:    return S_CHECK_H;
            default:   return S_DONE;
        endcase
    endfunction

    assign is_check = (state_q == S_CHECK_A) || (state_q == S_CHECK_B) || (state_q == S_CHECK_H);
    assign mism     = {(ReadData2 != expected(state_q, ~k_q)),
                       (ReadData1 != expected(state_q, k_q))} & {2{is_check}};
    assign err_sum  = ERR_SW'(err_count_q) + ERR_SW'(mism[0]) + ERR_SW'(mism[1]);

    // Sequencing and result accumulation.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_port_d = fail_port_q;
        err_count_d = err_count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d     = S_FILL_A;
                    k_d         = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b1;
                    fail_addr_d = '0;
                    fail_port_d = '0;
                    err_count_d = '0;
                end
            end
            default: begin
                k_d = k_q + ADDRBITS'(1);
                if (k_q == K_LAST) begin
                    state_d = next_sweep(state_q);
                    if (state_d == S_DONE) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
                if (|mism) begin
                    pass_d      = 1'b0;
                    err_count_d = err_sum[ERR_SW-1] ? ERR_MAX : err_sum[ERR_W-1:0];
                    if (pass_q) begin
                        fail_port_d = mism;
                        fail_addr_d = mism[0] ? k_q : ~k_q;
                    end
`ifdef REGFILE_BIST_STOP_ON_FAIL_EN
                    state_d = S_DONE;
                    k_d     = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end
            end
        endcase
    end

    // Port values for the upcoming cycle, so they are flop outputs yet track state and k.
    always_comb begin
        wr_data_d   = '0;
        wr_reg_d    = '0;
        reg_write_d = 1'b0;
        rd_reg1_d   = '0;
        rd_reg2_d   = '0;
        case (state_d)
            S_FILL_A: begin
                wr_reg_d    = k_d;
                wr_data_d   = pat_a(k_d);
                reg_write_d = 1'b1;
            end
            S_FILL_B: begin
                wr_reg_d    = k_d;
                wr_data_d   = ~pat_a(k_d);
                reg_write_d = 1'b1;
            end
            S_HOLD: begin
                wr_reg_d  = k_d;
                wr_data_d = HOLD_DATA;
            end
            S_CHECK_A, S_CHECK_B, S_CHECK_H: begin
                rd_reg1_d = k_d;
                rd_reg2_d = ~k_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_port_q <= '0;
            err_count_q <= '0;
            wr_data_q   <= '0;
            wr_reg_q    <= '0;
            reg_write_q <= 1'b0;
            rd_reg1_q   <= '0;
            rd_reg2_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_port_q <= fail_port_d;
            err_count_q <= err_count_d;
            wr_data_q   <= wr_data_d;
            wr_reg_q    <= wr_reg_d;
            reg_write_q <= reg_write_d;
            rd_reg1_q   <= rd_reg1_d;
            rd_reg2_q   <= rd_reg2_d;
        end
    end

    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Pass          = pass_q;
    assign FailAddr      = fail_addr_q;
    assign FailPort      = fail_port_q;
    assign ErrCount      = err_count_q;
    assign WriteData     = wr_data_q;
    assign WriteRegister = wr_reg_q;
    assign RegWrite      = reg_write_q;
    assign ReadRegister1 = rd_reg1_q;
    assign ReadRegister2 = rd_reg2_q;

endmodule

// File: doc/regfile_bist.md
# regfile_bist

Built-in self-test controller sitting directly upstream of the 32x32 register file: it owns the file's write port and both read ports while active and runs a fixed march test covering write enable, address decode, register zero and each read port independently. On completion it reports pass/fail, the first failing register and port, and an error count. The datapath muxes these ports back to the CPU when `Busy` is low; that mux is outside this block.

## Interface
- `WIDTH`, 32: data width.
- `ADDRBITS`, 5: register address width; the file holds 2^ADDRBITS registers, and N = 32 below.
- Synchronous, active-high reset; single clock `Clk`, reset port `Reset`.
- `Clk` in 1: clock; all state updates on posedge.
- `Reset` in 1: synchronous, active-high reset.
- `Start` in 1: start request, sampled only in IDLE or DONE.
- `Busy` out 1: test sequence in progress.
- `Done` out 1: sequence finished; level, held until next start or reset.
- `Pass` out 1: valid when `Done`; 1 means no mismatch.
- `FailAddr` out ADDRBITS: register address of the first mismatch.
- `FailPort` out 2: ports that mismatched in the first failing cycle; bit0 is port 1, bit1 is port 2.
- `ErrCount` out 8: saturating count of mismatching reads, counted per port.
- `ReadData1`, `ReadData2` in WIDTH: register file read data, combinational w.r.t. read address.
- `WriteData` out WIDTH, `WriteRegister` out ADDRBITS, `RegWrite` out 1: register file write port.
- `ReadRegister1`, `ReadRegister2` out ADDRBITS: register file read addresses.

## Operation
- States: IDLE, FILL_A, CHECK_A, FILL_B, CHECK_B, HOLD, CHECK_H, DONE. Each sweep state runs index k = 0..31, one register per cycle, then advances to the next state with k = 0.
- Patterns:
  - PA(k) = zero-extended k.
  - PB(k) = bitwise NOT of PA(k).
  - HOLD data is constant 0xDEADBEEF.
- FILL_A, FILL_B: `WriteRegister`=k, `WriteData`=PA(k) or PB(k), `RegWrite`=1.
- HOLD: `WriteRegister`=k, `WriteData`=0xDEADBEEF, `RegWrite`=0. A correct file must ignore these writes.
- CHECK_x: `ReadRegister1`=k, `ReadRegister2`=31−k.
  - Expected value for register r is 0 if r==0; otherwise PA(r) in CHECK_A, and PB(r) in CHECK_B and CHECK_H.
- `RegWrite`=0 in every state except FILL_A and FILL_B.
- On a mismatch in a CHECK cycle:
  - `Pass` clears.
  - `ErrCount` adds 1 per mismatching port, saturating at 255.
  - On the first mismatch only: `FailPort` latches the mismatch bits, and `FailAddr` latches k if port 1 mismatched, else 31−k.
- Start accepted (IDLE or DONE): `Pass`←1, `Done`←0, `ErrCount`←0, `FailAddr`←0, `FailPort`←0, then enter FILL_A.
- `Start` is ignored while `Busy` is high.

## Timing
- Reset values: `Busy`=0, `Done`=0, `Pass`=0, `FailAddr`=0, `FailPort`=0, `ErrCount`=0, `RegWrite`=0, `WriteData`=0, all address outputs 0; state IDLE, k=0.
- Port outputs decode from registered state and k, and are stable for the full cycle. The write lands on the posedge ending a FILL cycle. Read compare is sampled on the posedge ending a CHECK cycle.
- Edge E0 samples `Start` high. FILL_A k=0 occupies the cycle after E0. Six sweeps take 192 cycles. Edge E192 enters DONE, so `Done`=1 and `Busy`=0 from then on.
- `Busy`=1 from E0 through the cycle before E192.
- `Reset` mid-sequence: on the next edge all outputs return to reset values and the state goes to IDLE. No further writes are issued; register file contents are undefined.
- `Start` held high in DONE restarts at the next edge.

## Configuration
- `REGFILE_BIST_STOP_ON_FAIL_EN` defined: the first mismatch moves the state to DONE on the same edge that latches the failure. `ErrCount` reflects only that cycle (1 or 2).
- `REGFILE_BIST_STOP_ON_FAIL_EN` undefined: the full 192-cycle sequence always runs and `ErrCount` accumulates.

## Test plan
- Correct behavioural regfile, `Start` pulsed one cycle → `Busy` high for 192 cycles, then `Done`=1, `Pass`=1, `ErrCount`=0.
- Register 0 writable (stores writes) → `Pass`=0, `FailAddr`=0, `FailPort`=01, `ErrCount`=4 (CHECK_B and CHECK_H, port 1 at k=0 and port 2 at k=31).
- Write enable ignored (always writes) → first failure at CHECK_H k=0: `FailAddr`=31, `FailPort`=10, `ErrCount`=62.
- Port 2 always returns register 17 → `FailAddr`=31, `FailPort`=10, `ErrCount`=93.
- `Reset` asserted at cycle 50 of a run → next edge `Busy`=0, `RegWrite`=0, all status 0. A subsequent `Start` completes with `Pass`=1 on a good file.
- With `REGFILE_BIST_STOP_ON_FAIL_EN`, write enable ignored → `Done` at edge E161, `ErrCount`=1, `FailAddr`=31, `FailPort`=10.
